// File: rtl/jtag_host.sv
// jtag_host -- command-driven JTAG TAP master.
//
// A command is one of: a TAP reset sequence, an IR scan or a DR scan of
// 1..64 bits. Every scan starts and ends in Run-Test/Idle. TCK is derived
// from clk by a reloadable divider: each TCK period is CLK_DIV clk cycles
// low followed by CLK_DIV clk cycles high (CLK_DIV legal range 1..255).
// TMS/TDI change only on the clk edge that starts a low half-period, and TDO
// is sampled on the clk edge that raises TCK. Leaving reset runs one
// automatic TAP reset sequence before the host reports ready.

module jtag_host #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // command channel
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_reset_i,
    input  logic        cmd_ir_i,
    input  logic [6:0]  cmd_len_i,
    input  logic [63:0] cmd_data_i,
    // response channel
    output logic        rsp_valid_o,
    output logic [63:0] rsp_data_o,
    // JTAG pins
    output logic        jtag_clk_o,
    output logic        jtag_tms_o,
    output logic        jtag_tdi_o,
    input  logic        jtag_tdo_i
);

    // Sequencer states. Each non-idle state covers one or more TCK periods:
    //   RESET   : 1,1,1,1,1,0              (cnt 0..5)
    //   SEL     : 1 (DR) or 1,1 (IR)        (Select-DR / Select-IR)
    //   CAPTURE : 0,0                       (into Capture, then into Shift)
    //   SHIFT   : len bits, TMS=1 on last   (cnt = shift bit index)
    //   EXIT    : 1                         (Exit1 -> Update)
    //   UPDATE  : 0                         (Update -> Run-Test/Idle)
    //   DONE    : one clk with the response pulse; still accepts a command
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RESET   = 3'd1;
    localparam logic [2:0] ST_SEL     = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_SHIFT   = 3'd4;
    localparam logic [2:0] ST_EXIT    = 3'd5;
    localparam logic [2:0] ST_UPDATE  = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    // Divider counts down from this value once per half-period.
    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

    // Sequencer position
    logic [2:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  div_q, div_d;

    // Latched command
    logic        ir_q, ir_d;
    logic [5:0]  last_q, last_d;
    logic [63:0] data_q, data_d;
    // 1 while running the sequence that follows rst_n; it produces no response
    logic        auto_q, auto_d;

    // Capture shift register and response
    logic [63:0] cap_q, cap_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;

    // Pin registers
    logic        tck_q, tck_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;

    // Position and pin values of the TCK period that follows the current one
    logic [2:0]  nxt_state;
    logic [5:0]  nxt_cnt;
    logic        nxt_tms;
    logic        nxt_tdi;
    logic        seq_end;

    // Requested length clamped to 1..64, expressed as the last shift bit index
    logic [5:0]  cmd_last;

    // Clamp the command length: 0 behaves as 1, anything above 64 as 64.
    always_comb begin
        if (cmd_len_i == 7'd0) begin
            cmd_last = 6'd0;
        end else if (cmd_len_i > 7'd64) begin
            cmd_last = 6'd63;
        end else begin
            cmd_last = 6'(cmd_len_i - 7'd1);
        end
    end

    // Work out where the sequence goes when the current TCK period ends.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        nxt_state = state_q;
        nxt_cnt   = cnt_q + 6'd1;
        nxt_tms   = 1'b0;
        nxt_tdi   = 1'b0;
        seq_end   = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (cnt_q == 6'd5) begin
                    seq_end = 1'b1;
                end else begin
                    nxt_tms = (nxt_cnt != 6'd5);
                end
            end
            ST_SEL: begin
                // one Select period for DR, two (Select-DR, Select-IR) for IR
                if (cnt_q == {5'd0, ir_q}) begin
                    nxt_state = ST_CAPTURE;
                    nxt_cnt   = 6'd0;
                end else begin
                    nxt_tms = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (cnt_q == 6'd1) begin
                    nxt_state = ST_SHIFT;
                    nxt_cnt   = 6'd0;
                    nxt_tms   = (last_q == 6'd0);
                    nxt_tdi   = data_q[0];
                end
            end
            ST_SHIFT: begin
                if (cnt_q == last_q) begin
                    nxt_state = ST_EXIT;
                    nxt_cnt   = 6'd0;
                    nxt_tms   = 1'b1;
                end else begin
                    nxt_tms = (nxt_cnt == last_q);
                    nxt_tdi = data_q[nxt_cnt];
                end
            end
            ST_EXIT: begin
                nxt_state = ST_UPDATE;
                nxt_cnt   = 6'd0;
            end
            default: begin
                // UPDATE is the final period of a scan
                seq_end = 1'b1;
            end
        endcase
    end

    // Command acceptance, TCK divider, TDO capture and sequence stepping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        ir_d        = ir_q;
        last_d      = last_q;
        data_d      = data_q;
        auto_d      = auto_q;
        cap_d       = cap_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Pins park low: the target sits in Run-Test/Idle.
                state_d = ST_IDLE;
                tck_d   = 1'b0;
                tms_d   = 1'b0;
                tdi_d   = 1'b0;
                if (cmd_valid_i) begin
                    // This edge starts the first low half-period.
                    state_d = cmd_reset_i ? ST_RESET : ST_SEL;
                    cnt_d   = 6'd0;
                    div_d   = DIV_RELOAD;
                    tms_d   = 1'b1;
                    ir_d    = cmd_ir_i;
                    last_d  = cmd_last;
                    data_d  = cmd_data_i;
                    cap_d   = '0;
                    auto_d  = 1'b0;
                end
            end
            default: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    // Reload at every TCK edge so long scans cannot drift.
                    div_d = DIV_RELOAD;
                    if (!tck_q) begin
                        // End of low half: TCK rises, TDO is sampled.
                        tck_d = 1'b1;
                        if (state_q == ST_SHIFT) begin
                            cap_d[cnt_q] = jtag_tdo_i;
                        end
                    end else begin
                        // End of high half: TCK falls, next period or finish.
                        tck_d = 1'b0;
                        if (seq_end) begin
                            cnt_d = 6'd0;
                            tms_d = 1'b0;
                            tdi_d = 1'b0;
                            if (auto_q) begin
                                state_d = ST_IDLE;
                            end else begin
                                // cap_q was cleared on acceptance, so a reset
                                // command reports all zeros.
                                state_d     = ST_DONE;
                                rsp_valid_d = 1'b1;
                                rsp_data_d  = cap_q;
                            end
                        end else begin
                            state_d = nxt_state;
                            cnt_d   = nxt_cnt;
                            tms_d   = nxt_tms;
                            tdi_d   = nxt_tdi;
                        end
                    end
                end
            end
        endcase
    end

    // State registers; reset aborts any scan and re-arms the automatic TAP reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            cnt_q       <= 6'd0;
            div_q       <= DIV_RELOAD;
            ir_q        <= 1'b0;
            last_q      <= 6'd0;
            data_q      <= '0;
            auto_q      <= 1'b1;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before this edge, independent of order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            ir_q        <= ir_d;
            last_q      <= last_d;
            data_q      <= data_d;
            auto_q      <= auto_d;
            cap_q       <= cap_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
        end
    end

    // Ready while idle and during the response cycle (back-to-back accept).
    assign cmd_ready_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign jtag_clk_o  = tck_q;
    assign jtag_tms_o  = tms_q;
    assign jtag_tdi_o  = tdi_q;

endmodule

// File: doc/jtag_host.md
JTAG_HOST -- requirements
Module: jtag_host

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per TCK half-period, legal range 1..255.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid_i, input, 1: command request.
REQ-005 SHALL have port cmd_ready_o, output, 1: host idle, can accept a command.
REQ-006 SHALL have port cmd_reset_i, input, 1: 1 = TAP reset sequence; len, data and ir are ignored.
REQ-007 SHALL have port cmd_ir_i, input, 1: 1 = IR scan, 0 = DR scan.
REQ-008 SHALL have port cmd_len_i, input, 7: shift length in bits.
REQ-009 SHALL have port cmd_data_i, input, 64: TDI data, shifted LSB first.
REQ-010 SHALL have port rsp_valid_o, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port rsp_data_o, output, 64: captured TDO bits.
REQ-012 SHALL have port jtag_clk_o, output, 1: TCK.
REQ-013 SHALL have port jtag_tms_o, output, 1: TMS.
REQ-014 SHALL have port jtag_tdi_o, output, 1: TDI.
REQ-015 SHALL have port jtag_tdo_i, input, 1: TDO from the target TAP.

Function
REQ-016 SHALL generate each TCK period as 2*CLK_DIV clk cycles: a low half-period followed by a high half-period.
REQ-017 SHALL update TMS and TDI only on the clk edge that starts a low half-period.
REQ-018 SHALL sample TDO on the clk edge where TCK rises.
REQ-019 SHALL hold TCK=0, TMS=0 and TDI=0 while idle; the target TAP then sits in Run-Test/Idle.
REQ-020 SHALL accept a command on a clk edge where cmd_valid_i=1 and cmd_ready_o=1; command inputs are registered on that edge.
REQ-021 SHALL drive cmd_ready_o low from the edge after acceptance until completion.
REQ-022 SHALL ignore cmd_valid_i while cmd_ready_o=0.
REQ-023 SHALL use these states: IDLE, RESET, SEL, CAPTURE, SHIFT, EXIT, UPDATE, DONE.
REQ-024 SHALL, for a reset command, drive the TMS sequence 1,1,1,1,1,0 (6 TCK).
REQ-025 SHALL, for a DR scan, drive the TMS sequence 1,0,0, then len bits, then 1,0 (len+5 TCK total).
REQ-026 SHALL, for an IR scan, drive the TMS sequence 1,1,0,0, then len bits, then 1,0 (len+6 TCK total).
REQ-027 SHALL, during the len shift bits, drive TMS=0 except TMS=1 on the last shift bit (enters Exit1).
REQ-028 SHALL drive TDI = cmd_data[i] on shift bit i, and TDI=0 outside the shift bits.
REQ-029 SHALL store the TDO sampled on shift bit i into rsp_data_o[i]; bits at index len and above SHALL be 0.
REQ-030 SHALL treat len 0 as 1 and len above 64 as 64.
REQ-031 SHALL, on a reset command, return rsp_data_o = 0.
REQ-032 SHALL pulse rsp_valid_o for exactly one clk on the edge that completes the last TCK high half-period; TCK returns low on the same edge.
REQ-033 SHALL raise cmd_ready_o in the same cycle as the rsp_valid_o pulse.
REQ-034 SHALL hold rsp_data_o stable until the next command completes.
REQ-035 SHALL accept a back-to-back command on the rsp_valid_o cycle.
REQ-036 SHALL reload the divider counter at every TCK edge; there is no drift across long scans.

Reset
REQ-037 SHALL, while rst_n=0, drive these values immediately and asynchronously: jtag_clk_o=0, jtag_tms_o=1, jtag_tdi_o=0, cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, state=RESET.
REQ-038 SHALL, after rst_n rises, run one automatic reset sequence (REQ-024) and then enter IDLE with cmd_ready_o=1; rsp_valid_o SHALL NOT pulse for this sequence.
REQ-039 SHALL, when reset asserts mid-scan, abort the scan: no rsp_valid_o is produced and the partial rsp is discarded.

Verification
REQ-040 SHALL cover: CLK_DIV=2, rst_n released -> TMS 1,1,1,1,1,0 across 6 TCKs; cmd_ready_o=1 exactly 24 clk after release; no rsp_valid_o.
REQ-041 SHALL cover: DR scan, len 32, data 0x12345678, TDO looped to TDI -> TMS 1,0,0,0x31,1,1,0 (37 TCK); rsp_data_o=0x12345678; one rsp_valid_o pulse.
REQ-042 SHALL cover: IR scan, len 5, data 0x11, against a TAP model capturing IR=0b00001 -> TMS 1,1,0,0,0,0,0,0,1,1,0; TDI bits 1,0,0,0,1; rsp_data_o=0x01; the model's IR=0x11.
REQ-043 SHALL cover: len 0 with loopback and data 0x3 -> 1 shift bit, rsp_data_o=0x1; len 100 -> 64 shift bits, 69 TCK.
REQ-044 SHALL cover: cmd_valid_i held high across a scan with a second command queued -> second command accepted on the rsp_valid_o cycle; no TCK gap beyond one low half-period.
REQ-045 SHALL cover: rst_n pulsed low during shift bit 10 -> TCK=0 and TMS=1 in the same cycle; no rsp_valid_o; automatic reset sequence after release.
